// File: rtl/soi_fault_injector.sv
// soi_fault_injector
//   Injection / observation engine for signals of interest (SOIs). Takes one
//   host command at a time (read, force, flip, release), applies it to one SOI
//   after a programmable delay and for a programmable duration, then returns a
//   response. Sits between the DUT's functional flop outputs and their users.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   command handshake
//   req_op                0=read 1=force 2=flip 3=release
//   req_idx               target SOI index (out-of-range flagged via rsp_err)
//   req_val               force value
//   req_delay             cycles between accept and application
//   req_dur               override length in cycles, 0 = permanent
//   soi_in / soi_out      functional SOI values / values after override
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_err     read/applied value, index-out-of-range flag
//   busy                  command in progress
module soi_fault_injector #(
  parameter int N_SOI = 8,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             req_val,
  input  logic [CNT_W-1:0] req_delay,
  input  logic [CNT_W-1:0] req_dur,
  input  logic [N_SOI-1:0] soi_in,
  output logic [N_SOI-1:0] soi_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int SEL_W = (N_SOI > 1) ? $clog2(N_SOI) : 1;
  localparam logic [IDX_W:0] N_SOI_X = N_SOI[IDX_W:0];

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_FORCE, OP_FLIP, OP_RELEASE} op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               val_q, val_d;
  logic [CNT_W-1:0]   dur_q, dur_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_SOI-1:0]   mask_q, mask_d;
  logic [N_SOI-1:0]   ovr_q, ovr_d;
  logic               rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               app_val;

  assign soi_out   = (mask_q & ovr_q) | (~mask_q & soi_in);
  assign req_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      sel_q      <= '0;
      val_q      <= 1'b0;
      dur_q      <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      ovr_q      <= '0;
      rsp_data_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      dur_q      <= dur_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      ovr_q      <= ovr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    val_d      = val_q;
    dur_d      = dur_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    ovr_d      = ovr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    // flip freezes the inverted functional value seen at the application edge
    app_val    = (op_q == OP_FORCE) ? val_q : ~soi_in[sel_q];

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d       = op_t'(req_op);
          val_d      = req_val;
          dur_d      = req_dur;
          rsp_data_d = 1'b0;
          if ({1'b0, req_idx} >= N_SOI_X) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            rsp_err_d = 1'b0;
            sel_d     = req_idx[SEL_W-1:0];
            cnt_d     = req_delay;
            state_d   = WAIT;
          end
        end
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          unique case (op_q)
            OP_READ: begin
              rsp_data_d = soi_out[sel_q];
              state_d    = RESP;
            end
            OP_FORCE, OP_FLIP: begin
              mask_d[sel_q] = 1'b1;
              ovr_d[sel_q]  = app_val;
              rsp_data_d    = app_val;
              if (dur_q == '0) begin
                state_d = RESP;
              end else begin
                // ACTIVE clears on its cnt==0 edge, so dur-1 yields dur visible cycles
                cnt_d   = dur_q - CNT_W'(1);
                state_d = ACTIVE;
              end
            end
            OP_RELEASE: begin
              rsp_data_d    = soi_in[sel_q];
              mask_d[sel_q] = 1'b0;
              state_d       = RESP;
            end
            default: state_d = RESP;
          endcase
        end
      end

      ACTIVE: begin
        if (cnt_q == '0) begin
          mask_d[sel_q] = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_soi_fault_injector.sv
module tb_soi_fault_injector;

  localparam int N_SOI = 8;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [IDX_W-1:0] req_idx;
  logic             req_val;
  logic [CNT_W-1:0] req_delay;
  logic [CNT_W-1:0] req_dur;
  logic [N_SOI-1:0] soi_in;
  logic [N_SOI-1:0] soi_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_data;
  logic             rsp_err;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // reference model: per-SOI override flag and value
  bit m_mask [N_SOI];
  bit m_ovr  [N_SOI];

  soi_fault_injector #(.N_SOI(N_SOI), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_idx(req_idx), .req_val(req_val), .req_delay(req_delay), .req_dur(req_dur),
    .soi_in(soi_in), .soi_out(soi_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N_SOI-1:0] mout(input logic [N_SOI-1:0] s);
    logic [N_SOI-1:0] r;
    for (int i = 0; i < N_SOI; i++) r[i] = m_mask[i] ? m_ovr[i] : s[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command starting in IDLE (called at posedge+1), follow it to the
  // response, hold the response for 'hold' cycles with a competing request,
  // then complete the handshake. rnd randomises soi_in every cycle.
  task automatic run_cmd(input int op, input int idx, input bit v, input int dly,
                         input int dur, input int hold, input bit rnd,
                         input logic [N_SOI-1:0] s0);
    logic [N_SOI-1:0] s_edge;
    logic [N_SOI-1:0] pre;
    bit bad, timed;
    logic exp_d;
    int total;
    bad   = (idx >= N_SOI);
    timed = (op == 1 || op == 2) && (dur > 0);
    exp_d = 1'b0;
    soi_in    = s0;
    req_valid = 1'b1;
    req_op    = op[1:0];
    req_idx   = idx[IDX_W-1:0];
    req_val   = v;
    req_delay = dly[CNT_W-1:0];
    req_dur   = dur[CNT_W-1:0];
    #1;
    chk("req_ready_idle", req_ready, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!bad) begin
      total = dly + 1 + (timed ? dur : 0);
      for (int k = 1; k <= total; k++) begin
        chk("busy_run", busy, 1);
        chk("rsp_valid_run", rsp_valid, 0);
        chk("req_ready_run", req_ready, 0);
        chk("soi_out_run", soi_out, mout(soi_in));
        if (rnd) soi_in = $urandom;
        s_edge = soi_in;
        @(posedge clk);
        if (k == dly + 1) begin
          pre = mout(s_edge);
          case (op)
            0: exp_d = pre[idx];
            1: begin m_mask[idx] = 1'b1; m_ovr[idx] = v; exp_d = v; end
            2: begin m_mask[idx] = 1'b1; m_ovr[idx] = ~s_edge[idx]; exp_d = ~s_edge[idx]; end
            default: begin exp_d = s_edge[idx]; m_mask[idx] = 1'b0; end
          endcase
        end
        if (timed && k == total) m_mask[idx] = 1'b0;
        #1;
      end
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", rsp_err, bad);
    chk("soi_out_resp", soi_out, mout(soi_in));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_op    = 2'($urandom);
      req_idx   = 4'($urandom);
      req_delay = '0;
      req_dur   = '0;
      if (rnd) soi_in = $urandom;
      #1;
      chk("req_ready_resp", req_ready, 0);
      @(posedge clk); #1;
      chk("rsp_valid_hold", rsp_valid, 1);
      chk("rsp_data_hold", rsp_data, exp_d);
      chk("rsp_err_hold", rsp_err, bad);
      chk("soi_out_hold", soi_out, mout(soi_in));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_done", rsp_valid, 0);
    chk("busy_done", busy, 0);
    chk("soi_out_done", soi_out, mout(soi_in));
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_idx = '0; req_val = 1'b0;
    req_delay = '0; req_dur = '0; rsp_ready = 1'b0; soi_in = 8'hA5;
    for (int i = 0; i < N_SOI; i++) begin m_mask[i] = 1'b0; m_ovr[i] = 1'b0; end
    #1 reset = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_soi_out", soi_out, 8'hA5);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // read idx 2 with no delay
    run_cmd(0, 2, 1'b0, 0, 0, 0, 1'b0, 8'hA5);
    // timed force idx 0: delay 2, duration 3
    run_cmd(1, 0, 1'b1, 2, 3, 0, 1'b0, 8'h00);
    // permanent flip idx 7, then toggle soi_in[7] and release
    run_cmd(2, 7, 1'b0, 0, 0, 0, 1'b0, 8'h80);
    soi_in = 8'h00; #1;
    chk("flip_frozen", soi_out, 8'h00);
    run_cmd(3, 7, 1'b0, 0, 0, 0, 1'b0, 8'h80);
    chk("release_out", soi_out, 8'h80);
    // out-of-range index
    run_cmd(0, 12, 1'b0, 0, 0, 0, 1'b0, 8'h5A);
    chk("err_soi_out", soi_out, 8'h5A);
    // held response with competing request, then follow-up read and release
    run_cmd(1, 3, 1'b1, 1, 0, 5, 1'b0, 8'h00);
    run_cmd(0, 3, 1'b0, 0, 0, 0, 1'b0, 8'h00);
    run_cmd(3, 3, 1'b0, 0, 0, 0, 1'b0, 8'h00);
    chk("release3_out", soi_out, 8'h00);

    // reset abort in the middle of a long override
    soi_in = 8'h0F; req_valid = 1'b1; req_op = 2'd1; req_idx = 4'd4; req_val = 1'b1;
    req_delay = '0; req_dur = 16'd100;
    @(posedge clk); #1;           // accept
    req_valid = 1'b0;
    @(posedge clk); #1;           // application edge, now ACTIVE
    chk("abort_pre_ovr", soi_out, 8'h1F);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < N_SOI; i++) m_mask[i] = 1'b0;
    #1;
    chk("abort_soi_out", soi_out, mout(soi_in));
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_stale_rsp", rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end

    // randomized commands against the model
    for (int n = 0; n < 60; n++) begin
      run_cmd($urandom_range(0, 3), $urandom_range(0, 11), 1'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
              1'b1, 8'($urandom));
    end

    // maximum delay must count fully
    run_cmd(0, 1, 1'b0, 65535, 0, 0, 1'b0, 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
